div_share_ctrl: RTL

- Shares one divide16 instance (WIDTH-bit signed, multi-cycle restoring divider) between N_REQ requesters.
- Arbitrates requests round-robin, sequences the divider's start/done handshake and screens out illegal operations.
- Returns quotient or remainder according to opcode: 6'b010101 = quotient, 6'b010110 = remainder.
- Sits between the issue stage and the divider, so requesters never drive the divider directly.

---
 rtl/div_pkg.sv | 26 ++
 rtl/divide16.sv | 104 ++++++++++
 rtl/div_share_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared opcodes and state encodings for the shared divider controller
// and the multi-cycle divider it owns.
package div_pkg;

    localparam logic [5:0] OP_DIVQ = 6'b010101;
    localparam logic [5:0] OP_DIVR = 6'b010110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } ctrl_state_e;

    typedef enum logic [1:0] {
        DV_IDLE = 2'd0,
        DV_INIT = 2'd1,
        DV_RUN  = 2'd2,
        DV_FIX  = 2'd3
    } dv_state_e;

    function automatic logic is_div_op(input logic [5:0] op);
        return (op == OP_DIVQ) || (op == OP_DIVR);
    endfunction

endpackage

// File: rtl/divide16.sv
// Signed restoring divider, one quotient bit per cycle.
// done is sticky and only drops in the INIT cycle of the next divide.
module divide16
    import div_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    dv_state_e        st_q, st_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             done_q, done_d;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;

    always_comb begin
        st_d   = st_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        done_d = done_q;
        trial  = {rem_q, quo_q[WIDTH-1]};
        diff   = trial - {1'b0, dvs_q};
        unique case (st_q)
            DV_IDLE: begin
                if (start) st_d = DV_INIT;
            end
            DV_INIT: begin
                done_d = 1'b0;
                quo_d  = dividend[WIDTH-1] ? -dividend : dividend;
                dvs_d  = divisor[WIDTH-1] ? -divisor : divisor;
                rem_d  = '0;
                qneg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                rneg_d = dividend[WIDTH-1];
                cnt_d  = '0;
                st_d   = DV_RUN;
            end
            DV_RUN: begin
                // borrow out of the trial subtract means "does not fit"
                if (!diff[WIDTH]) begin
                    rem_d = diff[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) st_d = DV_FIX;
            end
            DV_FIX: begin
                quo_d  = qneg_q ? -quo_q : quo_q;
                rem_d  = rneg_q ? -rem_q : rem_q;
                done_d = 1'b1;
                st_d   = DV_IDLE;
            end
            default: st_d = DV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= DV_IDLE;
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
            done_q <= done_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign done      = done_q;

endmodule

// File: rtl/div_share_ctrl.sv
// Round-robin front end sharing one divide16 between N_REQ requesters,
// with illegal-op screening and a watchdog on each divide.
module div_share_ctrl
    import div_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [6*N_REQ-1:0]     req_op,
    input  logic [WIDTH*N_REQ-1:0] req_a,
    input  logic [WIDTH*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]       rsp_data,
    output logic                   rsp_err,
    input  logic [N_REQ-1:0]       rsp_ack,
    output logic                   busy
);

    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WDW = $clog2(TIMEOUT) + 1;

    ctrl_state_e      state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [5:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       guard_q, guard_d;
    logic [WDW-1:0]   wd_cnt_q, wd_cnt_d;
    logic             div_start_q, div_start_d;
    logic             wd_rst_q, wd_rst_d;
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic             busy_q, busy_d;

    logic [IDW:0]     pick;
    logic [IDW-1:0]   pick_id;
    logic [5:0]       pick_op;
    logic [WIDTH-1:0] pick_a;
    logic [WIDTH-1:0] pick_b;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] div_rem;
    logic             div_done;
    logic             div_rst;

    // Returns {found, index}: first requester at or above p, wrapping.
    function automatic logic [IDW:0] rr_pick(
        input logic [N_REQ-1:0] r,
        input logic [IDW-1:0]   p
    );
        logic [IDW:0] res;
        int           j;
        res = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = int'(p) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (r[j]) res = {1'b1, IDW'(j)};
        end
        return res;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [IDW-1:0] i);
        logic [N_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    always_comb begin
        pick    = rr_pick(req, rr_ptr_q);
        pick_id = pick[IDW-1:0];
        pick_op = req_op[int'(pick_id)*6 +: 6];
        pick_a  = req_a[int'(pick_id)*WIDTH +: WIDTH];
        pick_b  = req_b[int'(pick_id)*WIDTH +: WIDTH];
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        guard_d     = guard_q;
        wd_cnt_d    = wd_cnt_q;
        div_start_d = 1'b0;
        wd_rst_d    = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        gnt         = '0;
        unique case (state_q)
            IDLE: begin
                if (pick[IDW] && !rst) begin
                    gnt  = onehot(pick_id);
                    id_d = pick_id;
                    op_d = pick_op;
                    a_d  = pick_a;
                    b_d  = pick_b;
                    if (!is_div_op(pick_op) || (pick_b == '0)) begin
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = '0;
                        rsp_valid_d = onehot(pick_id);
                        state_d     = RESP;
                    end else begin
                        div_start_d = 1'b1;
                        state_d     = ISSUE;
                    end
                end
            end
            ISSUE: begin
                guard_d  = 2'd2;
                wd_cnt_d = '0;
                state_d  = WAIT;
            end
            WAIT: begin
                if (guard_q != 2'd0) guard_d = guard_q - 2'd1;
                wd_cnt_d = wd_cnt_q + 1'b1;
                // done from the previous divide is stale until guard drains
                if ((guard_q == 2'd0) && div_done) begin
                    rsp_data_d  = (op_q == OP_DIVQ) ? div_quo : div_rem;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = onehot(id_q);
                    state_d     = RESP;
                end else if (wd_cnt_q == WDW'(TIMEOUT - 1)) begin
                    wd_rst_d    = 1'b1;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = onehot(id_q);
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ack[id_q]) begin
                    rsp_valid_d = '0;
                    rr_ptr_d    = (int'(id_q) == N_REQ - 1) ? '0 : id_q + 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            guard_q     <= '0;
            wd_cnt_q    <= '0;
            div_start_q <= 1'b0;
            wd_rst_q    <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            guard_q     <= guard_d;
            wd_cnt_q    <= wd_cnt_d;
            div_start_q <= div_start_d;
            wd_rst_q    <= wd_rst_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    assign div_rst = rst | wd_rst_q;

    divide16 #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk      (clk),
        .rst      (div_rst),
        .start    (div_start_q),
        .dividend (a_q),
        .divisor  (b_q),
        .quotient (div_quo),
        .remainder(div_rem),
        .done     (div_done)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;

endmodule
